// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode/flag in, per-cycle control strobes out.
interface multi_cycle_ctrl_if;
  logic [5:0] Opcode;
  logic       zero;
  logic       PCWre;
  logic       IRWre;
  logic       RegWre;
  logic       WR;
  logic       RD;
  logic       InsMemRW;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic       ExtSel;
  logic       DBDataSrc;
  logic       WrRegDSrc;
  logic [1:0] RegDst;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;
  logic [2:0] state;

  // Datapath side: supplies the IR opcode and ALU flag, consumes controls.
  modport master (
    output Opcode, zero,
    input  PCWre, IRWre, RegWre, WR, RD, InsMemRW,
    input  ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc,
    input  RegDst, PCSrc, ALUOp, state
  );

  // Controller side.
  modport slave (
    input  Opcode, zero,
    output PCWre, IRWre, RegWre, WR, RD, InsMemRW,
    output ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc,
    output RegDst, PCSrc, ALUOp, state
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: IF/ID/EXE/MEM/WB sequencing with
// controls decoded combinationally from the current state and the live opcode.
module multi_cycle_ctrl #(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic                  CLK,
  input  logic                  Reset,
  multi_cycle_ctrl_if.slave     bus
);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_OR    = 6'b010011;
  localparam logic [5:0] OP_XORI  = 6'b010100;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;

  // Bit 3 only separates HALT from IF; the visible state is the low 3 bits.
  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_LD  = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000
  } state_t;

  state_t cur, nxt;

  logic       is_r, is_imm, is_lw, is_sw, is_beq, is_bne;
  logic       is_j, is_jr, is_jal, known, is_halt;
  logic [2:0] alu_op;
  logic       src_a, src_b, ext;

  // Opcode decode into instruction classes and static datapath selects.
  always_comb begin
    is_r   = 1'b0;
    is_imm = 1'b0;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    is_beq = 1'b0;
    is_bne = 1'b0;
    is_j   = 1'b0;
    is_jr  = 1'b0;
    is_jal = 1'b0;
    known  = 1'b1;
    alu_op = 3'b000;
    src_a  = 1'b0;
    src_b  = 1'b0;
    ext    = 1'b0;
    is_halt = (bus.Opcode == HALT_OP);
    case (bus.Opcode)
      OP_ADD:   is_r = 1'b1;
      OP_SUB:   begin is_r = 1'b1; alu_op = 3'b001; end
      OP_ADDIU: begin is_imm = 1'b1; src_b = 1'b1; ext = 1'b1; end
      OP_ANDI:  begin is_imm = 1'b1; src_b = 1'b1; alu_op = 3'b010; end
      OP_AND:   begin is_r = 1'b1; alu_op = 3'b010; end
      OP_ORI:   begin is_imm = 1'b1; src_b = 1'b1; alu_op = 3'b011; end
      OP_OR:    begin is_r = 1'b1; alu_op = 3'b011; end
      OP_XORI:  begin is_imm = 1'b1; src_b = 1'b1; alu_op = 3'b100; end
      OP_SLL:   begin is_r = 1'b1; src_a = 1'b1; alu_op = 3'b101; end
      OP_SLT:   begin is_r = 1'b1; alu_op = 3'b110; end
      OP_SW:    begin is_sw = 1'b1; src_b = 1'b1; ext = 1'b1; end
      OP_LW:    begin is_lw = 1'b1; src_b = 1'b1; ext = 1'b1; end
      OP_BEQ:   begin is_beq = 1'b1; alu_op = 3'b001; ext = 1'b1; end
      OP_BNE:   begin is_bne = 1'b1; alu_op = 3'b001; ext = 1'b1; end
      OP_J:     is_j = 1'b1;
      OP_JR:    is_jr = 1'b1;
      OP_JAL:   is_jal = 1'b1;
      default:  known = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) cur <= S_IF;
    else        cur <= nxt;
  end

  // Next-state: jumps and unknown opcodes retire in ID, HALT is sticky.
  always_comb begin
    nxt = S_IF;
    case (cur)
      S_IF:     nxt = S_ID;
      S_ID: begin
        if (is_halt)                                nxt = S_HALT;
        else if (is_j || is_jr || is_jal || !known) nxt = S_IF;
        else if (is_beq || is_bne)                  nxt = S_EXE_BR;
        else if (is_lw || is_sw)                    nxt = S_EXE_LS;
        else                                        nxt = S_EXE_AL;
      end
      S_EXE_AL: nxt = S_WB_AL;
      S_WB_AL:  nxt = S_IF;
      S_EXE_BR: nxt = S_IF;
      S_EXE_LS: nxt = S_MEM;
      S_MEM:    nxt = is_lw ? S_WB_LD : S_IF;
      S_WB_LD:  nxt = S_IF;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_IF;
    endcase
  end

  // Control outputs; write strobes are additionally killed while Reset is low.
  always_comb begin
    bus.PCWre     = 1'b0;
    bus.IRWre     = 1'b0;
    bus.RegWre    = 1'b0;
    bus.WR        = 1'b0;
    bus.RD        = 1'b0;
    bus.InsMemRW  = 1'b0;
    bus.DBDataSrc = 1'b0;
    bus.ALUSrcA   = src_a;
    bus.ALUSrcB   = src_b;
    bus.ExtSel    = ext;
    bus.ALUOp     = alu_op;
    bus.WrRegDSrc = !is_jal;
    bus.RegDst    = is_r ? 2'b10 : ((is_imm || is_lw) ? 2'b01 : 2'b00);
    bus.PCSrc     = (is_j || is_jal) ? 2'b11 : (is_jr ? 2'b10 : 2'b00);
    bus.state     = 3'(cur);
    case (cur)
      S_IF: begin
        bus.IRWre    = 1'b1;
        bus.InsMemRW = 1'b1;
      end
      S_ID: begin
        bus.PCWre  = !is_halt && (is_j || is_jr || is_jal || !known);
        bus.RegWre = is_jal;
      end
      S_EXE_BR: begin
        bus.PCWre = 1'b1;
        if ((is_beq && bus.zero) || (is_bne && !bus.zero)) bus.PCSrc = 2'b01;
      end
      S_MEM: begin
        bus.WR    = is_sw;
        bus.RD    = is_lw;
        bus.PCWre = is_sw;
      end
      S_WB_AL: begin
        bus.PCWre  = 1'b1;
        bus.RegWre = 1'b1;
      end
      S_WB_LD: begin
        bus.PCWre     = 1'b1;
        bus.RegWre    = 1'b1;
        bus.DBDataSrc = 1'b1;
      end
      default: ;
    endcase
    if (!Reset) begin
      bus.PCWre  = 1'b0;
      bus.IRWre  = 1'b0;
      bus.RegWre = 1'b0;
      bus.WR     = 1'b0;
      bus.RD     = 1'b0;
    end
  end

endmodule
